// File: rtl/mix_vga_ramp_control.sv
// VGA gain control: clamps a requested level, then applies it immediately or
// slews one LSB per prescaled tick, driving a registered thermometer code.
module mix_vga_ramp_control #(
   parameter  int IN_WIDTH  = 3,
   parameter  int OUT_WIDTH = 6,
   parameter  int STEP_DIV  = 16,
   localparam int LVL_W     = $clog2(OUT_WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [IN_WIDTH-1:0]  vga_control_in,
   input  logic                 load,
   input  logic                 ramp_en,
   output logic [OUT_WIDTH-1:0] vga_control_out,
   output logic [LVL_W-1:0]     level,
   output logic                 busy,
   output logic                 done
);

   localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic [LVL_W-1:0]     level_q, level_d;
   logic [LVL_W-1:0]     target_q, target_d;
   logic                 mode_q, mode_d;
   logic [PRE_W-1:0]     presc_q, presc_d;
   logic [OUT_WIDTH-1:0] therm_q, therm_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [LVL_W-1:0]     clamp_lvl;

   always_comb begin
      if (int'(vga_control_in) > OUT_WIDTH) clamp_lvl = LVL_W'(OUT_WIDTH);
      else                                  clamp_lvl = LVL_W'(vga_control_in);
   end

   always_comb begin
      level_d  = level_q;
      target_d = target_q;
      mode_d   = mode_q;
      presc_d  = '0;
      done_d   = 1'b0;

      if (load) begin
         // Load wins over a coincident tick: the step is dropped, not deferred.
         target_d = clamp_lvl;
         mode_d   = ramp_en;
         if (!ramp_en) level_d = clamp_lvl;
         done_d   = (level_d == target_d);
      end else if (mode_q && (level_q != target_q)) begin
         if (presc_q == PRE_W'(STEP_DIV - 1)) begin
            level_d = (level_q < target_q) ? level_q + LVL_W'(1) : level_q - LVL_W'(1);
         end else begin
            presc_d = presc_q + PRE_W'(1);
         end
         done_d = (level_d == target_q);
      end

      busy_d = (level_d != target_d);

      therm_d = '0;
      for (int i = 0; i < OUT_WIDTH; i++) therm_d[i] = (i < int'(level_d));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         level_q  <= '0;
         target_q <= '0;
         mode_q   <= 1'b0;
         presc_q  <= '0;
         therm_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         level_q  <= level_d;
         target_q <= target_d;
         mode_q   <= mode_d;
         presc_q  <= presc_d;
         therm_q  <= therm_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign vga_control_out = therm_q;
   assign level           = level_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_mix_vga_ramp_control.sv
// Directed bench for mix_vga_ramp_control with OUT_WIDTH=6, STEP_DIV=4.
module tb_mix_vga_ramp_control;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [2:0] vga_control_in = '0;
   logic       load = 1'b0;
   logic       ramp_en = 1'b0;
   logic [5:0] vga_control_out;
   logic [2:0] level;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   mix_vga_ramp_control #(.IN_WIDTH(3), .OUT_WIDTH(6), .STEP_DIV(4)) u_dut (
      .clk             (clk),
      .rstn            (rstn),
      .vga_control_in  (vga_control_in),
      .load            (load),
      .ramp_en         (ramp_en),
      .vga_control_out (vga_control_out),
      .level           (level),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int lvl, input int bsy, input int dn);
      check_val({tag, ".level"}, int'(level), lvl);
      check_val({tag, ".out"}, int'(vga_control_out), (1 << lvl) - 1);
      check_val({tag, ".busy"}, int'(busy), bsy);
      check_val({tag, ".done"}, int'(done), dn);
   endtask

   task automatic do_load(input int val, input logic ramp);
      vga_control_in = 3'(val);
      ramp_en = ramp;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      // Reset held over several edges, then released.
      step(); step();
      check_all("rst_hold", 0, 0, 0);
      rstn = 1'b1;
      step();
      check_all("rst_rel", 0, 0, 0);

      // Immediate load of 3.
      do_load(3, 1'b0);
      check_all("imm3", 3, 0, 1);
      check_val("imm3.out_lit", int'(vga_control_out), 7);
      step();
      check_all("imm3_after", 3, 0, 0);

      // Clamp 7 -> 6.
      do_load(7, 1'b0);
      check_all("clamp", 6, 0, 1);
      check_val("clamp.out_lit", int'(vga_control_out), 63);
      step();

      // Asynchronous reset mid-cycle.
      #3 rstn = 1'b0;
      #1 check_all("arst_mid", 0, 0, 0);
      step();
      check_all("arst_held", 0, 0, 0);
      rstn = 1'b1;
      step();
      check_all("arst_rel", 0, 0, 0);

      // Ramp up 0 -> 4: steps every 4 edges after the load edge.
      do_load(4, 1'b1);
      check_all("rup_k", 0, 1, 0);
      for (int e = 1; e <= 16; e++) begin
         step();
         check_all($sformatf("rup_e%0d", e), e / 4, (e < 16) ? 1 : 0, (e == 16) ? 1 : 0);
      end
      step();
      check_all("rup_end", 4, 0, 0);

      // Ramp down toward 0, retarget at a pending tick when level is 2.
      do_load(0, 1'b1);
      check_all("rdn_k", 4, 1, 0);
      for (int e = 1; e <= 11; e++) begin
         step();
         check_all($sformatf("rdn_e%0d", e), 4 - e / 4, 1, 0);
      end
      do_load(0, 1'b1);
      check_all("retgt_k", 2, 1, 0);
      for (int e = 1; e <= 8; e++) begin
         step();
         check_all($sformatf("retgt_e%0d", e), (e < 4) ? 2 : ((e < 8) ? 1 : 0),
                   (e < 8) ? 1 : 0, (e == 8) ? 1 : 0);
      end
      step();
      check_all("retgt_end", 0, 0, 0);

      // Reload same level in ramp mode.
      do_load(5, 1'b0);
      check_all("set5", 5, 0, 1);
      step();
      check_all("set5_after", 5, 0, 0);
      do_load(5, 1'b1);
      check_all("same5", 5, 0, 1);
      check_val("same5.out_lit", int'(vga_control_out), 31);
      step();
      check_all("same5_after", 5, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
